reset_seq_timer: RTL
====================

Name: reset_seq_timer

Overview:
Synthesizable, parametrised successor to the testbench clock-and-reset helper. Generates NUM_RST_OUT staggered active-high reset outputs after a programmable assertion delay and supports software-requested reset re-sequencing. Provides NUM_TIMERS independent cycle-count timers (one-shot or periodic) with expiry pulse, toggle event and readable remaining count. Sits at the top of each block-level environment and drives the DUT resets, the timeouts and the drain waits.

Parameters:
NUM_RST_OUT, 2, number of reset outputs (>=1)
RST_STAGGER, 4, cycles between successive reset-output releases (>=1)
RST_DLY_W, 16, width of rst_delay
NUM_TIMERS, 4, number of timer channels (>=1)
CNT_W, 32, timer count width

Ports:
clock  in  1  sole clock, rising edge
reset_n  in  1  asynchronous active-low reset
sw_reset_req  in  1  one-cycle request to restart the reset sequence
rst_delay  in  RST_DLY_W  assertion length D in cycles; must be static while the sequence runs
rst_out  out  NUM_RST_OUT  active-high resets to the DUT domains
rst_done  out  1  high when all of rst_out are released
timer_start  in  NUM_TIMERS  per-channel start/restart pulse
timer_stop  in  NUM_TIMERS  per-channel abort pulse
timer_periodic  in  NUM_TIMERS  mode, sampled on start: 1=periodic, 0=one-shot
timer_load  in  NUM_TIMERS*CNT_W  count N per channel, channel i at bits [i*CNT_W +: CNT_W]
timer_busy  out  NUM_TIMERS  channel counting
timer_expired  out  NUM_TIMERS  one-cycle expiry pulse
timer_toggle  out  NUM_TIMERS  flips on every expiry
timer_remaining  out  NUM_TIMERS*CNT_W  cycles left; 0 when idle

Behaviour:
- Reset values while reset_n is low (async): rst_out all 1, rst_done 0, reset FSM in ASSERT with counter 0, all timer outputs 0.
- Reset FSM states: ASSERT, RELEASE, DONE. Edge 1 is the first rising edge with reset_n high.
- ASSERT: cycle counter increments. Go to RELEASE at the edge where counter == D. D=0 gives a 1-cycle minimum.
- Net timing: rst_out[i] clears at edge D+1+i*RST_STAGGER. rst_done sets one edge after the last release, i.e. edge D+2+(NUM_RST_OUT-1)*RST_STAGGER. FSM is then DONE.
- sw_reset_req in any state: at the next edge all rst_out go to 1, rst_done goes to 0, counter goes to 0, FSM goes to ASSERT. That edge counts as edge 0 for the timing above.
- sw_reset_req repeated mid-sequence restarts the sequence again.
- sw_reset_req does not affect the timers. Only reset_n clears them.
- Timer channel, start at edge e with value N: busy=1 and remaining=N at edge e, mode latched. remaining decrements on each later edge.
- Expiry: on the edge where remaining goes 1->0, timer_expired=1 for exactly one cycle and timer_toggle inverts.
  - One-shot: busy clears at that edge.
  - Periodic: remaining reloads to the latched N at that edge, so expiries occur every N cycles.
- N=0 behaves as N=1.
- Start while busy: restart with the new N and mode; no expiry for the abandoned count.
- Stop: busy=0 and remaining=0 at the next edge, no expiry.
- Start and stop in the same cycle: start wins.
- Stop in the cycle whose edge would expire: stop wins, no pulse, no toggle.
- Stop while idle: no effect.
- Channels are fully independent; simultaneous expiries on several channels all pulse in the same cycle.
- Counters saturate at 0 and never wrap. N = 2^CNT_W-1 is legal.
- reset_n assertion mid-operation: all state returns immediately to the reset values.

Test Plan:
- D=3, NUM_RST_OUT=2, RST_STAGGER=4, reset_n released -> rst_out[0] falls at edge 4, rst_out[1] at edge 8, rst_done rises at edge 9.
- sw_reset_req pulse at edge 20 (FSM in DONE), D=3 -> rst_out=2'b11 at edge 20, rst_out[0] falls at edge 24, rst_out[1] at edge 28, rst_done rises at edge 29.
- Timer 0 one-shot, N=5, start at edge 10 -> remaining reads 5,4,3,2,1; expired pulses at edge 15; busy falls at 15; toggle 0->1.
- Timer 1 periodic, N=3, start at edge 0 -> expired at edges 3, 6, 9; toggle flips each time; stop at edge 10 -> busy=0, remaining=0, no further pulses.
- Timer 2 N=4 started at edge 0, restart with N=2 at edge 2 -> single expiry at edge 4; stop asserted together with the expiry edge of another run -> no pulse.
- reset_n asserted mid-sequence and while timers are busy -> rst_out all 1, all timers idle immediately (asynchronously); sequence restarts correctly after release.

Source files
------------

// File: rtl/reset_seq_timer_if.sv
// Timer channel bundle between the reset/timer block and its users.
// master drives the per-channel controls, slave is the timer block.
interface reset_seq_timer_if #(
    parameter int NUM_TIMERS = 4,
    parameter int CNT_W      = 32
);
    logic [NUM_TIMERS-1:0]       timer_start;
    logic [NUM_TIMERS-1:0]       timer_stop;
    logic [NUM_TIMERS-1:0]       timer_periodic;
    logic [NUM_TIMERS*CNT_W-1:0] timer_load;
    logic [NUM_TIMERS-1:0]       timer_busy;
    logic [NUM_TIMERS-1:0]       timer_expired;
    logic [NUM_TIMERS-1:0]       timer_toggle;
    logic [NUM_TIMERS*CNT_W-1:0] timer_remaining;

    modport master (
        output timer_start, timer_stop, timer_periodic, timer_load,
        input  timer_busy, timer_expired, timer_toggle, timer_remaining
    );

    modport slave (
        input  timer_start, timer_stop, timer_periodic, timer_load,
        output timer_busy, timer_expired, timer_toggle, timer_remaining
    );
endinterface

// File: rtl/reset_seq_timer.sv
// Staggered reset sequencer with software re-sequencing, plus independent
// one-shot/periodic cycle timers.
//
//   state      | meaning
//   ST_ASSERT  | all resets held, counting the assertion delay
//   ST_RELEASE | releasing rst_out[i] every RST_STAGGER cycles
//   ST_DONE    | all resets released, rst_done high
module reset_seq_timer #(
    parameter int NUM_RST_OUT = 2,
    parameter int RST_STAGGER = 4,
    parameter int RST_DLY_W   = 16,
    parameter int NUM_TIMERS  = 4,
    parameter int CNT_W       = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   sw_reset_req,
    input  logic [RST_DLY_W-1:0]   rst_delay,
    output logic [NUM_RST_OUT-1:0] rst_out,
    output logic                   rst_done,
    reset_seq_timer_if.slave       tmr
);
    localparam int REL_SPAN = (NUM_RST_OUT - 1) * RST_STAGGER;
    localparam int REL_W    = $clog2(REL_SPAN + 2);
    localparam int SEQ_W    = (RST_DLY_W > REL_W) ? RST_DLY_W : REL_W;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [SEQ_W-1:0]       cnt, cnt_nxt;
    logic [NUM_RST_OUT-1:0] rst_out_nxt;
    logic                   rst_done_nxt;

    // Outputs are registered so the DUT resets never see decode glitches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_ASSERT;
            cnt      <= '0;
            rst_out  <= '1;
            rst_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rst_out  <= rst_out_nxt;
            rst_done <= rst_done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (sw_reset_req) begin
            state_nxt = ST_ASSERT;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (cnt == SEQ_W'(rst_delay)) begin
                        state_nxt = ST_RELEASE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + SEQ_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt == SEQ_W'(REL_SPAN)) begin
                        state_nxt = ST_DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + SEQ_W'(1);
                    end
                end
                ST_DONE: ;
                default: begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // In RELEASE the counter holds cycles since entry; output i drops at i*RST_STAGGER.
    always_comb begin
        rst_out_nxt  = '1;
        rst_done_nxt = 1'b0;
        case (state_nxt)
            ST_RELEASE: begin
                for (int i = 0; i < NUM_RST_OUT; i++)
                    rst_out_nxt[i] = (cnt_nxt < SEQ_W'(i * RST_STAGGER));
            end
            ST_DONE: begin
                rst_out_nxt  = '0;
                rst_done_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    logic [NUM_TIMERS-1:0] busy_q, periodic_q, expired_q, toggle_q;
    logic [CNT_W-1:0]      rem_q    [NUM_TIMERS];
    logic [CNT_W-1:0]      reload_q [NUM_TIMERS];
    logic [CNT_W-1:0]      load_eff [NUM_TIMERS];

    always_comb begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
            load_eff[i] = tmr.timer_load[i*CNT_W +: CNT_W];
            if (load_eff[i] == '0)
                load_eff[i] = CNT_W'(1);
        end
    end

    // Priority per channel: start, then stop, then counting.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q     <= '0;
            periodic_q <= '0;
            expired_q  <= '0;
            toggle_q   <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                rem_q[i]    <= '0;
                reload_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                expired_q[i] <= 1'b0;
                if (tmr.timer_start[i]) begin
                    busy_q[i]     <= 1'b1;
                    periodic_q[i] <= tmr.timer_periodic[i];
                    reload_q[i]   <= load_eff[i];
                    rem_q[i]      <= load_eff[i];
                end else if (tmr.timer_stop[i]) begin
                    busy_q[i] <= 1'b0;
                    rem_q[i]  <= '0;
                end else if (busy_q[i]) begin
                    if (rem_q[i] == CNT_W'(1)) begin
                        expired_q[i] <= 1'b1;
                        toggle_q[i]  <= ~toggle_q[i];
                        if (periodic_q[i]) begin
                            rem_q[i] <= reload_q[i];
                        end else begin
                            busy_q[i] <= 1'b0;
                            rem_q[i]  <= '0;
                        end
                    end else begin
                        rem_q[i] <= rem_q[i] - CNT_W'(1);
                    end
                end
            end
        end
    end

    assign tmr.timer_busy    = busy_q;
    assign tmr.timer_expired = expired_q;
    assign tmr.timer_toggle  = toggle_q;

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_rem
        assign tmr.timer_remaining[g*CNT_W +: CNT_W] = rem_q[g];
    end
endmodule
